zero_skip_mac: RTL and testbench

//  Processing-element MAC that consumes the operand stream and its Zero flag from the

---
 rtl/zero_skip_mac.sv | 120 ++++++++++++
 tb/tb_zero_skip_mac.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/zero_skip_mac.sv
// zero_skip_mac: processing-element MAC with zero-pair skipping.
// Zero-flagged operand pairs bypass the multiplier: the operand registers keep
// their old value so the multiplier inputs do not toggle, and no product is
// added. One dot product is accumulated per in_last-terminated burst and then
// presented, with beat/skip statistics, on a valid/ready result port.
//
// state | meaning
// ------+-------------------------------------------------------------
// ACC   | accepting operand beats, accumulating products
// DRAIN | last beat taken; final pending product is added this cycle
// OUT   | result held on out_*; waits for out_ready
module zero_skip_mac #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_ACC = 40,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_A-1:0]   A,
  input  logic [WIDTH_B-1:0]   B,
  input  logic                 Zero,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_ACC-1:0] out_acc,
  output logic [CNT_W-1:0]     out_beats,
  output logic [CNT_W-1:0]     out_skips
);

  localparam int PW = WIDTH_A + WIDTH_B;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state, next_state;

  logic signed [WIDTH_A-1:0]   a_r;
  logic signed [WIDTH_B-1:0]   b_r;
  logic                        p_v;
  logic        [WIDTH_ACC-1:0] acc;
  logic        [CNT_W-1:0]     beats;
  logic        [CNT_W-1:0]     skips;

  logic                        accept;
  logic                        done;
  logic signed [PW-1:0]        prod;
  logic signed [WIDTH_ACC-1:0] prod_ext;

  assign accept   = in_valid & in_ready;
  assign done     = out_valid & out_ready;
  assign prod     = a_r * b_r;
  assign prod_ext = WIDTH_ACC'(prod);

  assign out_acc   = acc;
  assign out_beats = beats;
  assign out_skips = skips;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) next_state = DRAIN;
      end
      DRAIN: next_state = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ACC;
      end
      default: next_state = ACC;
    endcase
  end

  // Operand stage, product accumulation and saturating burst statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      p_v   <= 1'b0;
      acc   <= '0;
      beats <= '0;
      skips <= '0;
    end else begin
      p_v <= accept & ~Zero;
      if (accept && !Zero) begin
        a_r <= A;
        b_r <= B;
      end
      if (accept) begin
        if (beats != '1) beats <= beats + CNT_W'(1);
        if (Zero && (skips != '1)) skips <= skips + CNT_W'(1);
      end
      if (p_v) acc <= acc + prod_ext;
      // The handshake closes the burst; nothing can be accepted in OUT, so
      // clearing here cannot collide with a new beat.
      if (done) begin
        acc   <= '0;
        beats <= '0;
        skips <= '0;
        p_v   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zero_skip_mac.sv
// Directed bench for zero_skip_mac: table of bursts plus hand-written
// sequences for operand hold, backpressure, mid-burst reset and wrap/saturate.
module tb_zero_skip_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, Zero, in_last, out_valid, out_ready;
  logic [15:0] A, B;
  logic [39:0] out_acc;
  logic [15:0] out_beats, out_skips;

  logic        s_in_valid, s_in_ready, s_zero, s_last, s_out_valid, s_out_ready;
  logic [15:0] s_a, s_b;
  logic [31:0] s_out_acc;
  logic [1:0]  s_out_beats, s_out_skips;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  zero_skip_mac dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Zero(Zero), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_beats(out_beats), .out_skips(out_skips)
  );

  zero_skip_mac #(.WIDTH_A(16), .WIDTH_B(16), .WIDTH_ACC(32), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .A(s_a), .B(s_b), .Zero(s_zero), .in_last(s_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_acc(s_out_acc), .out_beats(s_out_beats), .out_skips(s_out_skips)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        zero;
    logic        last;
    logic [39:0] exp_acc;
    logic [15:0] exp_beats;
    logic [15:0] exp_skips;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic z, input logic l);
    in_valid = 1'b1; A = a; B = b; Zero = z; in_last = l;
    step();
    in_valid = 1'b0; in_last = 1'b0; Zero = 1'b0;
  endtask

  // Called right after the last beat's accept edge: checks latency and result,
  // then completes the output handshake.
  task automatic expect_result(input string name, input logic [39:0] acc,
                               input logic [15:0] nb, input logic [15:0] ns);
    check({name, " drain_valid"}, 64'(out_valid), 64'd0);
    step();
    check({name, " out_valid"}, 64'(out_valid), 64'd1);
    check({name, " out_acc"}, 64'(out_acc), 64'(acc));
    check({name, " out_beats"}, 64'(out_beats), 64'(nb));
    check({name, " out_skips"}, 64'(out_skips), 64'(ns));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, " post_valid"}, 64'(out_valid), 64'd0);
    check({name, " post_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Zero = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_zero = 1'b0; s_last = 1'b0; s_out_ready = 1'b0;

    // Bursts: (3,4)+(-2,5)+skip(7,9) = 2; single (-32768)^2 = 2^30;
    // all-Zero burst = 0; (-100*50)+(3*-7) = -5021.
    vecs.push_back('{16'd3,      16'd4,      1'b0, 1'b0, 40'd0, 16'd0, 16'd0});
    vecs.push_back('{16'hFFFE,   16'd5,      1'b0, 1'b0, 40'd0, 16'd0, 16'd0});
    vecs.push_back('{16'd7,      16'd9,      1'b1, 1'b1, 40'd2, 16'd3, 16'd1});
    vecs.push_back('{16'h8000,   16'h8000,   1'b0, 1'b1, 40'h0040000000, 16'd1, 16'd0});
    vecs.push_back('{16'h1111,   16'h2222,   1'b1, 1'b0, 40'd0, 16'd0, 16'd0});
    vecs.push_back('{16'h7FFF,   16'h7FFF,   1'b1, 1'b1, 40'd0, 16'd2, 16'd2});
    vecs.push_back('{16'hFF9C,   16'd50,     1'b0, 1'b0, 40'd0, 16'd0, 16'd0});
    vecs.push_back('{16'd3,      16'hFFF9,   1'b0, 1'b1, 40'hFFFFFFEC63, 16'd2, 16'd0});

    step(); step();
    rst = 1'b0;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_acc", 64'(out_acc), 64'd0);
    check("reset out_beats", 64'(out_beats), 64'd0);
    check("reset out_skips", 64'(out_skips), 64'd0);
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].zero, vecs[i].last);
      if (vecs[i].last)
        expect_result($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_beats, vecs[i].exp_skips);
    end

    // Zero beat must leave operand registers untouched and add nothing.
    send(16'd2, 16'd3, 1'b0, 1'b0);
    send(16'h1234, 16'h5678, 1'b1, 1'b0);
    check("hold a_r", 64'(dut.a_r), 64'd2);
    check("hold b_r", 64'(dut.b_r), 64'd3);
    send(16'h1234, 16'h5678, 1'b1, 1'b1);
    check("hold a_r last", 64'(dut.a_r), 64'd2);
    expect_result("zero_hold", 40'd6, 16'd3, 16'd2);

    // Backpressure: 10 cycles in OUT with beats offered that must be refused.
    send(16'd5, 16'd6, 1'b0, 1'b1);
    step();
    in_valid = 1'b1; A = 16'd100; B = 16'd100; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp%0d out_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d in_ready", c), 64'(in_ready), 64'd0);
      check($sformatf("bp%0d out_acc", c), 64'(out_acc), 64'd30);
      check($sformatf("bp%0d out_beats", c), 64'(out_beats), 64'd1);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp release in_ready", 64'(in_ready), 64'd1);
    send(16'd1, 16'd2, 1'b0, 1'b1);
    expect_result("after_bp", 40'd2, 16'd1, 16'd0);

    // Reset mid-burst discards the partial sum and pending product.
    send(16'd10, 16'd10, 1'b0, 1'b0);
    send(16'd20, 16'd20, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    send(16'd1, 16'd1, 1'b0, 1'b1);
    expect_result("after_rst", 40'd1, 16'd1, 16'd0);

    // 32-bit accumulator wraps, 2-bit counters saturate.
    // 5 * 32767^2 = 5368381445 -> mod 2^32 = 1073414149.
    for (int k = 0; k < 10; k++) begin
      s_in_valid = 1'b1; s_a = 16'h7FFF; s_b = 16'h7FFF;
      s_zero = (k >= 5); s_last = (k == 9);
      step();
    end
    s_in_valid = 1'b0; s_last = 1'b0; s_zero = 1'b0;
    check("small drain_valid", 64'(s_out_valid), 64'd0);
    step();
    check("small out_valid", 64'(s_out_valid), 64'd1);
    check("small out_acc wrap", 64'(s_out_acc), 64'd1073414149);
    check("small out_beats sat", 64'(s_out_beats), 64'd3);
    check("small out_skips sat", 64'(s_out_skips), 64'd3);
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    check("small cleared acc", 64'(s_out_acc), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
